// File: rtl/time_set_if.sv
// time_set_if: button/time inputs and load/display outputs of the time-set controller
interface time_set_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] cur_hour;
  logic [7:0] cur_min;
  logic [7:0] cur_sec;
  logic       run_en;
  logic       load_strobe;
  logic [1:0] load_field;
  logic [7:0] load_data;
  logic [1:0] edit_field;
  logic       blink;
  modport master (
    output btn_mode, btn_inc, cur_hour, cur_min, cur_sec,
    input  run_en, load_strobe, load_field, load_data, edit_field, blink
  );
  modport slave (
    input  btn_mode, btn_inc, cur_hour, cur_min, cur_sec,
    output run_en, load_strobe, load_field, load_data, edit_field, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: two-button clock time setting with debounce, BCD staging, load strobe and blink
module time_set_ctrl #(
  parameter int DEB_CYCLES   = 1000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input logic       clk,
  input logic       rst,
  time_set_if.slave bus
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  // state encoding doubles as the field code: RUN=00, SET_H=01, SET_M=10, SET_S=11
  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;
  state_t        state;
  logic [1:0]    btn, s1, s2, stb, pls;
  logic [DW-1:0] cnt [2];
  logic [BW-1:0] bcnt;
  logic [7:0]    stage, stage_inc, lim;
  logic          mode_p, inc_p;
  assign btn    = {bus.btn_inc, bus.btn_mode};
  assign mode_p = pls[0];
  assign inc_p  = pls[1];
  // synchronize and debounce both buttons; one-cycle pulse when a high level is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      stb <= '0;
      pls <= '0;
      cnt <= '{default: '0};
    end else begin
      s1 <= btn;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        pls[i] <= s2[i] && !stb[i] && cnt[i] == DW'(DEB_CYCLES - 1);
        if (s2[i] == stb[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DEB_CYCLES - 1)) begin
          cnt[i] <= '0;
          stb[i] <= s2[i];
        end else cnt[i] <= cnt[i] + DW'(1);
      end
    end
  end
  // BCD increment of the staging value; out-of-range values fall back to 00
  always_comb begin
    lim       = state == SET_H ? 8'h23 : 8'h59;
    stage_inc = stage >= lim ? 8'h00 :
                stage[3:0] >= 4'd9 ? {stage[7:4] + 4'd1, 4'd0} : stage + 8'd1;
  end
  // mode FSM with staging, load strobe, registered status outputs and blink timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      stage           <= '0;
      bcnt            <= '0;
      bus.run_en      <= 1'b1;
      bus.load_strobe <= 1'b0;
      bus.load_field  <= 2'b00;
      bus.load_data   <= 8'h00;
      bus.edit_field  <= 2'b00;
      bus.blink       <= 1'b1;
    end else begin
      bus.load_strobe <= mode_p && state != RUN;
      bus.load_field  <= mode_p ? 2'(state) : 2'b00;
      bus.load_data   <= mode_p && state != RUN ? stage : 8'h00;
      if (mode_p) begin
        state          <= state_t'(2'(state) + 2'd1);
        stage          <= state == RUN ? bus.cur_hour : state == SET_H ? bus.cur_min :
                          state == SET_M ? bus.cur_sec : 8'h00;
        bus.run_en     <= state == SET_S;
        bus.edit_field <= 2'(state) + 2'd1;
        bus.blink      <= 1'b1;
        bcnt           <= '0;
      end else if (state == RUN) begin
        bus.blink <= 1'b1;
        bcnt      <= '0;
      end else if (inc_p) begin
        stage     <= stage_inc;
        bus.blink <= 1'b1;
        bcnt      <= '0;
      end else if (bcnt == BW'(BLINK_CYCLES - 1)) begin
        bus.blink <= ~bus.blink;
        bcnt      <= '0;
      end else bcnt <= bcnt + BW'(1);
    end
  end
endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, number of consecutive clk cycles a synchronized button level must differ from the stable level before it is accepted.
REQ-002 Parameter BLINK_CYCLES, default 25000000, number of clk cycles per blink half-period.
REQ-003 clk  in  1  single system clock; all state is clocked on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 btn_mode  in  1  raw, asynchronous, active-high mode push-button.
REQ-006 btn_inc  in  1  raw, asynchronous, active-high increment push-button.
REQ-007 cur_hour  in  8  current hour from the time counter, packed BCD {tens,units}, 00..23.
REQ-008 cur_min  in  8  current minute, packed BCD, 00..59.
REQ-009 cur_sec  in  8  current second, packed BCD, 00..59.
REQ-010 run_en  out  1  high = the time counter may advance; low = counting frozen.
REQ-011 load_strobe  out  1  one-cycle pulse; the time counter loads load_data into the field named by load_field.
REQ-012 load_field  out  2  01 = hour, 10 = minute, 11 = second, 00 = none.
REQ-013 load_data  out  8  packed BCD value to load.
REQ-014 edit_field  out  2  field currently being edited, using the load_field encoding; 00 in RUN.
REQ-015 blink  out  1  display enable for the edited field's digits; 1 = visible.

Function
REQ-016 Each button passes through a 2-flop synchronizer, then a debounce counter that sets the stable level after DEB_CYCLES consecutive differing samples; any agreeing sample clears the counter.
REQ-017 A stable 0->1 transition produces exactly one internal pulse of one cycle (mode_p, inc_p); holding a button produces no repeats.
REQ-018 The FSM has exactly four states: RUN, SET_H, SET_M and SET_S.
REQ-019 On mode_p the FSM advances RUN->SET_H->SET_M->SET_S->RUN; with no mode_p the state holds.
REQ-020 On entering SET_H, SET_M or SET_S, an 8-bit staging register captures cur_hour, cur_min or cur_sec respectively, sampled in the cycle of mode_p.
REQ-021 inc_p in a SET state increments the staging value in BCD: units 9->0 with a carry to tens.
REQ-022 Hour staging wraps 23->00; minute and second staging wrap 59->00; no non-BCD value is ever produced.
REQ-023 inc_p in RUN is ignored.
REQ-024 When mode_p leaves a SET state, load_strobe is 1 in the next cycle only. In that cycle load_field carries the code of the field being left and load_data carries its staging value.
REQ-025 Outside a strobe cycle, load_field = 00 and load_data = 00.
REQ-026 Each SET visit produces exactly one load_strobe, even when the value is unchanged.
REQ-027 run_en = 1 only in RUN; it goes low in the cycle after mode_p leaves RUN and returns high in the cycle after mode_p leaves SET_S.
REQ-028 edit_field = 01, 10 or 11 in SET_H, SET_M or SET_S, and 00 in RUN; it is registered and follows the state with one cycle of latency.
REQ-029 blink = 1 in RUN. On entering any SET state, the blink counter clears and blink = 1; blink then toggles every BLINK_CYCLES cycles.
REQ-030 An inc_p forces blink = 1 and clears the blink counter.
REQ-031 When mode_p and inc_p occur in the same cycle, mode_p wins and inc_p is discarded.
REQ-032 load_data is taken from the staging value before any same-cycle inc_p.

Reset
REQ-033 While rst = 1, outputs are: state RUN, run_en = 1, load_strobe = 0, load_field = 00, load_data = 00, edit_field = 00, blink = 1.
REQ-034 While rst = 1, synchronizers, debounce counters, stable levels, staging and the blink counter are all 0.
REQ-035 rst asserted mid-edit abandons the edit with no load_strobe.
REQ-036 A button held through reset release produces a pulse once it has been debounced as high.

Verification (DEB_CYCLES=4, BLINK_CYCLES=8)
REQ-037 Glitch rejection: btn_mode high for 3 cycles, then low -> no state change; btn_mode held high 10 cycles -> exactly one transition RUN->SET_H, then run_en=0 and edit_field=01.
REQ-038 Hour wrap: cur_hour=8'h22, enter SET_H, 2 inc presses, then mode -> one load_strobe, load_field=01, load_data=8'h00; FSM is in SET_M.
REQ-039 Minute carry: cur_min=8'h39, enter SET_M, 1 inc, mode -> load_data=8'h40, load_field=10; then mode out of SET_S with cur_sec=8'h59 unchanged -> load_data=8'h59, load_field=11, run_en=1 next cycle.
REQ-040 Blink: in SET_S with no inc, blink toggles every 8 cycles; an inc pulse at cycle 5 of a low phase -> blink=1 the next cycle and the counter restarts.
REQ-041 Simultaneous: mode_p and inc_p in the same cycle in SET_H with staging 8'h05 -> load_data=8'h05, no increment.
REQ-042 Reset mid-edit: rst pulse while in SET_M after 3 incs -> all outputs at reset values, no load_strobe ever observed, run_en=1.
